// File: rtl/rv_decode_pkg.sv
// rv_decode_pkg: RV32 opcode constants, immediate formats and decode-stage FSM states
package rv_decode_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J} imm_t;

    typedef enum logic [1:0] {EMPTY, FULL, BUBBLE} state_t;

    function automatic imm_t imm_sel(input logic [6:0] op, input logic [2:0] f3);
        return (op == OP_LOAD || op == OP_JALR) ? IMM_I :
               op == OP_IMM    ? ((f3 == 3'b001 || f3 == 3'b101) ? IMM_SH : IMM_I) :
               op == OP_STORE  ? IMM_S :
               op == OP_BRANCH ? IMM_B :
               (op == OP_LUI || op == OP_AUIPC) ? IMM_U :
               op == OP_JAL    ? IMM_J : IMM_NONE;
    endfunction
endpackage

// File: rtl/decode_stage_if.sv
// decode_stage_if: fetch handshake, execute handshake and decoded fields of decode_stage
interface decode_stage_if #(parameter int XLEN = 32, parameter int PC_W = 32);
    logic            flush;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic [PC_W-1:0] in_pc;
    logic            out_valid;
    logic            out_ready;
    logic [6:0]      out_opcode;
    logic [4:0]      out_rd;
    logic [4:0]      out_rs1;
    logic [4:0]      out_rs2;
    logic [2:0]      out_funct3;
    logic [6:0]      out_funct7;
    logic [XLEN-1:0] out_imm;
    logic [PC_W-1:0] out_pc;
    logic            out_mem_flag;
    logic            out_illegal;
    logic            stall;

    modport master (
        output flush, in_valid, in_instr, in_pc, out_ready,
        input  in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
               out_funct7, out_imm, out_pc, out_mem_flag, out_illegal, stall
    );

    modport slave (
        input  flush, in_valid, in_instr, in_pc, out_ready,
        output in_ready, out_valid, out_opcode, out_rd, out_rs1, out_rs2, out_funct3,
               out_funct7, out_imm, out_pc, out_mem_flag, out_illegal, stall
    );
endinterface

// File: rtl/imm_gen.sv
// imm_gen: combinational RV32 field, immediate and legality decode; M_EXT_EN makes funct7=0000001 R-type legal
module imm_gen
    import rv_decode_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]     instr,
    output logic [6:0]      opcode,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [XLEN-1:0] imm,
    output logic            mem_flag,
    output logic            illegal
);
`ifdef M_EXT_EN
    localparam bit M_OK = 1'b1;
`else
    localparam bit M_OK = 1'b0;
`endif

    imm_t        sel;
    logic        r_ok;
    logic [31:0] imm32;

    assign opcode   = instr[6:0];
    assign rd       = instr[11:7];
    assign funct3   = instr[14:12];
    assign funct7   = instr[31:25];
    assign rs1      = opcode inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_IMM, OP_REG, OP_JALR} ? instr[19:15] : 5'd0;
    assign rs2      = opcode inside {OP_STORE, OP_BRANCH, OP_REG} ? instr[24:20] : 5'd0;
    assign mem_flag = opcode == OP_LOAD || opcode == OP_STORE;
    assign sel      = imm_sel(opcode, funct3);
    assign r_ok     = funct7 == 7'b0000000 ||
                      (funct7 == 7'b0100000 && (funct3 == 3'b000 || funct3 == 3'b101)) ||
                      (M_OK && funct7 == 7'b0000001);

    always_comb begin
        illegal = 1'b0;
        case (opcode)
            OP_LOAD:   illegal = funct3 == 3'b011 || funct3 == 3'b110 || funct3 == 3'b111;
            OP_STORE:  illegal = funct3 > 3'b010;
            OP_BRANCH: illegal = funct3 == 3'b010 || funct3 == 3'b011;
            OP_IMM:    illegal = funct3 == 3'b001 ? funct7 != 7'b0000000 :
                                 funct3 == 3'b101 ? !(funct7 == 7'b0000000 || funct7 == 7'b0100000) : 1'b0;
            OP_REG:    illegal = !r_ok;
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_FENCE: illegal = 1'b0;
            default:   illegal = 1'b1;
        endcase
    end

    // Every format fits in 32 bits; widening to XLEN is a single sign-extending cast.
    assign imm32 = illegal      ? 32'd0 :
                   sel == IMM_I  ? {{20{instr[31]}}, instr[31:20]} :
                   sel == IMM_SH ? {27'd0, instr[24:20]} :
                   sel == IMM_S  ? {{20{instr[31]}}, instr[31:25], instr[11:7]} :
                   sel == IMM_B  ? {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0} :
                   sel == IMM_U  ? {instr[31:12], 12'd0} :
                   sel == IMM_J  ? {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0} :
                                   32'd0;
    assign imm = XLEN'($signed(imm32));
endmodule

// File: rtl/decode_stage.sv
// decode_stage: one-deep registered RV32 decode stage with load-use interlock
module decode_stage
    import rv_decode_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int LOAD_LAT = 1,
    parameter int PC_W     = 32
) (
    input logic           clk,
    input logic           rst,
    decode_stage_if.slave bus
);
    logic [6:0]      opcode;
    logic [6:0]      funct7;
    logic [4:0]      rd;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [2:0]      funct3;
    logic [XLEN-1:0] imm;
    logic            mem_flag;
    logic            illegal;
    state_t          state;
    logic [1:0]      cnt;
    logic [4:0]      ld_rd_q;
    logic [4:0]      ld_rd;
    logic            live;
    logic            held_load;
    logic            hazard;
    logic            accept;
    logic            drain;

    imm_gen #(.XLEN(XLEN)) u_imm_gen (
        .instr    (bus.in_instr),
        .opcode   (opcode),
        .rd       (rd),
        .rs1      (rs1),
        .rs2      (rs2),
        .funct3   (funct3),
        .funct7   (funct7),
        .imm      (imm),
        .mem_flag (mem_flag),
        .illegal  (illegal)
    );

    // Unused source registers decode as x0, so a nonzero ld_rd can never match them.
    assign held_load    = bus.out_valid && bus.out_opcode == OP_LOAD;
    assign ld_rd        = held_load ? bus.out_rd : cnt != 2'd0 ? ld_rd_q : 5'd0;
    assign hazard       = bus.in_valid && ld_rd != 5'd0 && (ld_rd == rs1 || ld_rd == rs2);
    assign bus.stall    = hazard;
    assign bus.out_valid = state == FULL;
    assign bus.in_ready = live && (!bus.out_valid || bus.out_ready) && !hazard && !bus.flush;
    assign accept       = bus.in_valid && bus.in_ready;
    assign drain        = bus.out_valid && bus.out_ready;

    // live holds in_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= EMPTY;
            cnt              <= 2'd0;
            ld_rd_q          <= 5'd0;
            live             <= 1'b0;
            bus.out_opcode   <= '0;
            bus.out_rd       <= '0;
            bus.out_rs1      <= '0;
            bus.out_rs2      <= '0;
            bus.out_funct3   <= '0;
            bus.out_funct7   <= '0;
            bus.out_imm      <= '0;
            bus.out_pc       <= '0;
            bus.out_mem_flag <= 1'b0;
            bus.out_illegal  <= 1'b0;
        end else begin
            live <= 1'b1;
            if (accept) begin
                bus.out_opcode   <= opcode;
                bus.out_rd       <= rd;
                bus.out_rs1      <= rs1;
                bus.out_rs2      <= rs2;
                bus.out_funct3   <= funct3;
                bus.out_funct7   <= funct7;
                bus.out_imm      <= imm;
                bus.out_pc       <= bus.in_pc;
                bus.out_mem_flag <= mem_flag;
                bus.out_illegal  <= illegal;
            end
            if (bus.flush) begin
                state <= EMPTY;
                cnt   <= 2'd0;
            end else begin
                cnt <= (drain && held_load) ? 2'(LOAD_LAT) : cnt != 2'd0 ? cnt - 2'd1 : 2'd0;
                if (drain && held_load) ld_rd_q <= bus.out_rd;
                case (state)
                    EMPTY:   if (accept) state <= FULL;
                    FULL:    if (drain && !accept) state <= (held_load && hazard) ? BUBBLE : EMPTY;
                    BUBBLE:  if (accept) state <= FULL; else if (cnt <= 2'd1) state <= EMPTY;
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: random and directed checks of decode_stage against a cycle-level reference model
module tb_decode_stage;
    localparam int LOAD_LAT = 1;
`ifdef M_EXT_EN
    localparam bit M_EXT = 1'b1;
`else
    localparam bit M_EXT = 1'b0;
`endif

    typedef struct packed {
        logic [6:0]  op;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [63:0] imm;
        logic        mem;
        logic        ill;
    } dec_t;

    logic clk;
    logic rst;
    int   n_vec;
    int   n_bad;
    logic m_v;
    dec_t m_d;
    logic [31:0] m_pc;
    logic [4:0]  m_ld;
    int   ld_age;
    logic [31:0] pc;
    logic st;

    decode_stage_if #(.XLEN(32), .PC_W(32)) bus ();
    decode_stage_if #(.XLEN(64), .PC_W(32)) bus64 ();

    assign bus64.flush     = bus.flush;
    assign bus64.in_valid  = bus.in_valid;
    assign bus64.in_instr  = bus.in_instr;
    assign bus64.in_pc     = bus.in_pc;
    assign bus64.out_ready = bus.out_ready;

    decode_stage #(.XLEN(32), .LOAD_LAT(LOAD_LAT), .PC_W(32)) dut (.clk(clk), .rst(rst), .bus(bus));
    decode_stage #(.XLEN(64), .LOAD_LAT(LOAD_LAT), .PC_W(32)) dut64 (.clk(clk), .rst(rst), .bus(bus64));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: observed %h, expected %h", tag, got, exp);
        end
    endtask

    // Reference decode written straight from the instruction-format tables.
    function automatic dec_t ref_dec(input logic [31:0] w);
        dec_t d;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [12:0] b;
        logic [20:0] j;
        logic r1;
        logic r2;
        f3 = w[14:12];
        f7 = w[31:25];
        d = '0;
        d.op = w[6:0];
        d.rd = w[11:7];
        d.f3 = f3;
        d.f7 = f7;
        r1 = 1'b0;
        r2 = 1'b0;
        case (w[6:0])
            7'h03: begin d.ill = f3 == 3 || f3 >= 6; d.imm = 64'($signed(w[31:20])); r1 = 1; d.mem = 1; end
            7'h23: begin d.ill = f3 > 2; d.imm = 64'($signed({w[31:25], w[11:7]})); r1 = 1; r2 = 1; d.mem = 1; end
            7'h63: begin
                d.ill = f3 == 2 || f3 == 3;
                b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
                d.imm = 64'($signed(b));
                r1 = 1; r2 = 1;
            end
            7'h13: begin
                r1 = 1;
                if (f3 == 1) begin d.ill = f7 != 0; d.imm = 64'(w[24:20]); end
                else if (f3 == 5) begin d.ill = !(f7 == 0 || f7 == 7'h20); d.imm = 64'(w[24:20]); end
                else d.imm = 64'($signed(w[31:20]));
            end
            7'h33: begin
                r1 = 1; r2 = 1;
                d.ill = !(f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5)) || (f7 == 1 && M_EXT));
            end
            7'h67: begin r1 = 1; d.imm = 64'($signed(w[31:20])); end
            7'h37, 7'h17: d.imm = 64'($signed({w[31:12], 12'd0}));
            7'h6f: begin j = {w[31], w[19:12], w[20], w[30:21], 1'b0}; d.imm = 64'($signed(j)); end
            7'h0f: ;
            default: d.ill = 1;
        endcase
        if (d.ill) d.imm = '0;
        d.rs1 = r1 ? w[19:15] : 5'd0;
        d.rs2 = r2 ? w[24:20] : 5'd0;
        return d;
    endfunction

    function automatic logic [31:0] rnd_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 11))
            0, 1, 2: w[6:0] = 7'h03;
            3:       w[6:0] = 7'h23;
            4:       w[6:0] = 7'h63;
            5:       w[6:0] = 7'h13;
            6, 7:    w[6:0] = 7'h33;
            8:       w[6:0] = 7'h37;
            9:       w[6:0] = 7'h6f;
            10:      w[6:0] = 7'h67;
            default: ;
        endcase
        w[11:7]  = 5'($urandom_range(0, 3));
        w[19:15] = 5'($urandom_range(0, 3));
        w[24:20] = 5'($urandom_range(0, 3));
        case ($urandom_range(0, 4))
            0, 1: w[31:25] = 7'h00;
            2:    w[31:25] = 7'h20;
            3:    w[31:25] = 7'h01;
            default: ;
        endcase
        return w;
    endfunction

    // One clock of stimulus: drive, check handshake, advance the model, check the register.
    task automatic step(input logic v, input logic [31:0] w, input logic ordy, input logic fl, output logic stl);
        dec_t d;
        logic [4:0] lr;
        logic hz;
        logic rdy;
        logic acc;
        logic drn;
        bus.in_valid = v;
        bus.in_instr = w;
        bus.in_pc = pc;
        bus.out_ready = ordy;
        bus.flush = fl;
        #1;
        d = ref_dec(w);
        lr = (m_v && m_d.op == 7'h03) ? m_d.rd : (ld_age < LOAD_LAT ? m_ld : 5'd0);
        hz = v && lr != 0 && (lr == d.rs1 || lr == d.rs2);
        rdy = (!m_v || ordy) && !hz && !fl;
        acc = v && rdy;
        drn = m_v && ordy;
        stl = bus.stall;
        check("stall", bus.stall, hz);
        check("in_ready", bus.in_ready, rdy);
        if (fl) begin
            m_v = 0;
            ld_age = 99;
        end else begin
            if (drn && m_d.op == 7'h03) begin m_ld = m_d.rd; ld_age = 0; end
            else if (ld_age < 99) ld_age++;
            if (acc) begin m_v = 1; m_d = d; m_pc = pc; end
            else if (drn) m_v = 0;
        end
        if (acc) pc += 4;
        @(negedge clk);
        check("out_valid", bus.out_valid, m_v);
        if (m_v) begin
            check("out_opcode", bus.out_opcode, m_d.op);
            check("out_rd", bus.out_rd, m_d.rd);
            check("out_rs1", bus.out_rs1, m_d.rs1);
            check("out_rs2", bus.out_rs2, m_d.rs2);
            check("out_funct3", bus.out_funct3, m_d.f3);
            check("out_funct7", bus.out_funct7, m_d.f7);
            check("out_imm", bus.out_imm, {32'd0, m_d.imm[31:0]});
            check("out_imm64", bus64.out_imm, m_d.imm);
            check("out_pc", bus.out_pc, m_pc);
            check("out_mem_flag", bus.out_mem_flag, m_d.mem);
            check("out_illegal", bus.out_illegal, m_d.ill);
        end
    endtask

    task automatic model_reset();
        m_v = 0;
        m_d = '0;
        m_pc = 0;
        m_ld = 0;
        ld_age = 99;
    endtask

    initial begin
        n_vec = 0;
        n_bad = 0;
        pc = 32'h100;
        model_reset();
        rst = 1;
        bus.flush = 0;
        bus.in_valid = 0;
        bus.in_instr = 0;
        bus.in_pc = 0;
        bus.out_ready = 0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_stall", bus.stall, 0);
        check("rst_in_ready", bus.in_ready, 0);
        check("rst_out_rd", bus.out_rd, 0);
        check("rst_out_imm", bus.out_imm, 0);
        check("rst_out_pc", bus.out_pc, 0);
        check("rst_out_opcode", bus.out_opcode, 0);
        check("rst_out_illegal", bus.out_illegal, 0);
        rst = 0;
        #1;
        check("in_ready_pre_edge", bus.in_ready, 0);
        @(negedge clk);
        check("in_ready_post_edge", bus.in_ready, 1);

        // ADDI x1,x0,5
        step(1, 32'h00500093, 1, 0, st);
        check("addi_rd", bus.out_rd, 1);
        check("addi_imm", bus.out_imm, 5);
        check("addi_illegal", bus.out_illegal, 0);

        // BEQ x0,x0,-4
        step(1, 32'hFE000EE3, 1, 0, st);
        check("beq_imm", bus.out_imm, 64'hFFFFFFFC);
        check("beq_rs2", bus.out_rs2, 0);
        check("beq_imm64", bus64.out_imm, 64'hFFFFFFFFFFFFFFFC);

        // LW x5 followed by dependent ADD x6,x5,x5
        step(1, 32'h0000A283, 1, 0, st);
        step(1, 32'h00528333, 1, 0, st);
        check("lu_stall_held", st, 1);
        step(1, 32'h00528333, 1, 0, st);
        check("lu_stall_after_drain", st, 1);
        step(1, 32'h00528333, 1, 0, st);
        check("lu_stall_clear", st, 0);
        check("lu_add_out", bus.out_rd, 6);
        step(0, 0, 1, 0, st);

        // MUL x0,x1,x2
        step(1, 32'h02208033, 1, 0, st);
        check("mul_illegal", bus.out_illegal, !M_EXT);

        // Backpressure: three held cycles, then one transfer per cycle
        step(1, 32'h00100113, 1, 0, st);
        for (int i = 0; i < 3; i++) step(1, 32'h00200193, 0, 0, st);
        for (int i = 0; i < 4; i++) step(1, {12'(i + 3), 5'd0, 3'd0, 5'(i + 8), 7'h13}, 1, 0, st);
        check("bp_last_imm", bus.out_imm, 6);

        // Flush while the load-use bubble is open
        step(1, 32'h0000A283, 1, 0, st);
        step(1, 32'h00528333, 1, 0, st);
        step(1, 32'h00528333, 1, 1, st);
        check("flush_out_valid", bus.out_valid, 0);
        step(1, 32'h00528333, 1, 0, st);
        check("flush_stall_next", st, 0);

        // Asynchronous reset while FULL
        step(1, 32'h00700213, 0, 0, st);
        bus.in_valid = 0;
        #2 rst = 1;
        #1;
        check("async_rst_valid", bus.out_valid, 0);
        check("async_rst_imm", bus.out_imm, 0);
        @(negedge clk);
        rst = 0;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 500; i++)
            step(($urandom % 4) != 0, rnd_instr(), ($urandom % 3) != 0, ($urandom % 25) == 0, st);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
